// File: rtl/sonar_range_ctrl.sv
// Ultrasonic range controller: fires periodic trigger pulses, times the echo and
// converts its width to whole centimetres with a cycles-per-cm sub-counter (no divider).
module sonar_range_ctrl #(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int DIST_W         = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic              i_echo,
  output logic              o_trig,
  output logic [DIST_W-1:0] o_distance_cm,
  output logic              o_valid,
  output logic              o_timeout,
  output logic              o_busy
);

  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int SUB_W = $clog2(CYCLES_PER_CM);

  localparam logic [PER_W-1:0]  TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [SUB_W-1:0]  SUB_ONE   = SUB_W'(1);
  localparam logic [DIST_W-1:0] CM_MAX    = '1;
  localparam logic [DIST_W-1:0] CM_ONE    = DIST_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  state_t state_r, state_next_s;

  logic              echo_meta_r, echo_sync_r, echo_prev_r;
  logic              rise_s, fall_s;
  logic [PER_W-1:0]  period_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [SUB_W-1:0]  sub_r, sub_step_s;
  logic [DIST_W-1:0] cm_r, cm_step_s;
  logic              count_s, to_hit_s, to_clr_s;
  logic              trig_r, valid_r, timeout_r, busy_r;
  logic [DIST_W-1:0] dist_r;

  assign rise_s = echo_sync_r & ~echo_prev_r;
  assign fall_s = ~echo_sync_r & echo_prev_r;

  // Two-flop synchroniser plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
      echo_prev_r <= 1'b0;
    end else begin
      echo_meta_r <= i_echo;
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= echo_sync_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state decode; count_s marks an echo-high cycle that adds to the range
  always_comb begin
    state_next_s = state_r;
    count_s      = 1'b0;
    to_hit_s     = 1'b0;
    to_clr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        to_clr_s = 1'b1;
        if (i_enable) state_next_s = TRIG;
        else          state_next_s = IDLE;
      end
      TRIG: begin
        to_clr_s = 1'b1;
        if (period_r == TRIG_LAST) state_next_s = WAIT_RISE;
        else                       state_next_s = TRIG;
      end
      WAIT_RISE: begin
        if (rise_s) begin
          state_next_s = MEASURE;
          count_s      = 1'b1;
          to_clr_s     = 1'b1;
        end else if (to_cnt_r == TO_LAST) begin
          state_next_s = HOLDOFF;
          to_hit_s     = 1'b1;
          to_clr_s     = 1'b1;
        end else begin
          state_next_s = WAIT_RISE;
        end
      end
      MEASURE: begin
        if (fall_s) begin
          state_next_s = DONE;
        end else if (!echo_sync_r) begin
          state_next_s = MEASURE;
        end else if (to_cnt_r == TO_LAST) begin
          state_next_s = HOLDOFF;
          to_hit_s     = 1'b1;
          to_clr_s     = 1'b1;
        end else begin
          state_next_s = MEASURE;
          count_s      = 1'b1;
        end
      end
      DONE:    state_next_s = HOLDOFF;
      HOLDOFF: begin
        if (period_r >= PER_LAST) begin
          if (i_enable) state_next_s = TRIG;
          else          state_next_s = IDLE;
        end else begin
          state_next_s = HOLDOFF;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // One step of the cm conversion: sub wraps every CYCLES_PER_CM, cm saturates
  always_comb begin
    sub_step_s = sub_r + SUB_ONE;
    cm_step_s  = cm_r;
    if (sub_r == SUB_LAST) begin
      sub_step_s = '0;
      if (cm_r == CM_MAX) cm_step_s = cm_r;
      else                cm_step_s = cm_r + CM_ONE;
    end else begin
      sub_step_s = sub_r + SUB_ONE;
      cm_step_s  = cm_r;
    end
  end

  // Period, timeout and conversion counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= '0;
      to_cnt_r <= '0;
      sub_r    <= '0;
      cm_r     <= '0;
    end else begin
      if (state_next_s == IDLE || (state_next_s == TRIG && state_r != TRIG))
        period_r <= '0;
      else
        period_r <= period_r + PER_ONE;

      if (to_clr_s)                             to_cnt_r <= '0;
      else if (state_r == WAIT_RISE || count_s) to_cnt_r <= to_cnt_r + TO_ONE;
      else                                      to_cnt_r <= to_cnt_r;

      if (state_r == IDLE || state_r == TRIG) begin
        sub_r <= '0;
        cm_r  <= '0;
      end else if (count_s) begin
        sub_r <= sub_step_s;
        cm_r  <= cm_step_s;
      end else begin
        sub_r <= sub_r;
        cm_r  <= cm_r;
      end
    end
  end

  // Registered outputs; trig and busy follow the state that is about to be entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_r    <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      dist_r    <= '0;
    end else begin
      trig_r    <= (state_next_s == TRIG);
      busy_r    <= (state_next_s != IDLE);
      valid_r   <= (state_r == DONE);
      timeout_r <= to_hit_s;
      if (state_r == DONE) dist_r <= cm_r;
      else                 dist_r <= dist_r;
    end
  end

  assign o_trig        = trig_r;
  assign o_busy        = busy_r;
  assign o_valid       = valid_r;
  assign o_timeout     = timeout_r;
  assign o_distance_cm = dist_r;

endmodule
